// File: rtl/stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stall_ctrl_pkg
//   Shared types and constants for the pipeline hazard / stall controller:
//   the T_use/T_new width and "not used" encoding, mult/div op encodings,
//   default mult/div latencies, the md busy-counter state type and the
//   GRF hazard compare helper used by the top.
// -----------------------------------------------------------------------------
package stall_ctrl_pkg;

    localparam int REG_W    = 5;   // GRF register number width
    localparam int T_W      = 2;   // T_use / T_new width
    localparam int MD_CNT_W = 4;   // mult/div busy counter width

    typedef logic [T_W-1:0]   t_val_t;
    typedef logic [REG_W-1:0] reg_num_t;

    // A source with T_use == 3 is never read, so it can never be younger
    // than any 2-bit T_new and never causes a stall.
    localparam t_val_t TUSE_NONE = 2'd3;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MFHI  = 3'd4,
        MD_OP_MFLO  = 3'd5,
        MD_OP_MTHI  = 3'd6,
        MD_OP_MTLO  = 3'd7
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A D-stage source X hazards against a producer when the producer writes
    // the same non-zero register and the result will not be ready in time.
    function automatic logic grf_hazard(
        input reg_num_t src,
        input t_val_t   tuse,
        input reg_num_t a3,
        input logic     we,
        input t_val_t   tnew
    );
        return (src != '0) && we && (a3 == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// stall_ctrl_if
//   Bundle between the pipeline and the stall controller.
//   Pipeline -> controller : D-stage sources and T_use, E/M producer info,
//                            mult/div issue and use flags.
//   Controller -> pipeline : stall, PC_en, D_en, E_clr, md_busy, md_done,
//                            stall_cnt.
//   master = pipeline side, slave = stall_ctrl side.
// -----------------------------------------------------------------------------
interface stall_ctrl_if
    import stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    reg_num_t         D_rs;
    reg_num_t         D_rt;
    t_val_t           D_Tuse_rs;
    t_val_t           D_Tuse_rt;
    logic             D_md_use;
    reg_num_t         E_A3;
    reg_num_t         M_A3;
    logic             E_RegWrite;
    logic             M_RegWrite;
    t_val_t           E_Tnew;
    t_val_t           M_Tnew;
    logic             E_md_start;
    logic             E_md_div;

    logic             stall;
    logic             PC_en;
    logic             D_en;
    logic             E_clr;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md_use,
        output E_A3, M_A3, E_RegWrite, M_RegWrite, E_Tnew, M_Tnew,
        output E_md_start, E_md_div,
        input  stall, PC_en, D_en, E_clr, md_busy, md_done, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_md_use,
        input  E_A3, M_A3, E_RegWrite, M_RegWrite, E_Tnew, M_Tnew,
        input  E_md_start, E_md_div,
        output stall, PC_en, D_en, E_clr, md_busy, md_done, stall_cnt
    );

endinterface

// File: rtl/stall_ctrl_md_busy_ctr.sv
// -----------------------------------------------------------------------------
// md_busy_ctr
//   Mult/div unit sequencer. An issue in E loads a down-counter with the
//   operation latency; md_busy is high for exactly that many cycles after the
//   issue edge and md_done pulses during the last of them.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MD_IDLE | unit free, waiting for md_start
//   MD_BUSY | operation in flight, md_cnt = busy cycles left incl. this one
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low reset (aborts any operation)
//   md_start in   mult/div issuing from E this cycle
//   md_div   in   1 = div/divu, 0 = mult/multu
//   md_busy  out  unit busy (registered)
//   md_done  out  last busy cycle (registered, one cycle)
// -----------------------------------------------------------------------------
module md_busy_ctr
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy,
    output logic md_done
);

    localparam logic [MD_CNT_W-1:0] MULT_N = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_N  = MD_CNT_W'(DIV_CYCLES);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [MD_CNT_W-1:0]   load_n;

    assign load_n = md_div ? DIV_N : MULT_N;

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d  = MD_BUSY;
                    md_cnt_d = load_n;
                    busy_d   = 1'b1;
                    done_d   = (load_n == MD_CNT_W'(1));
                end
            end
            MD_BUSY: begin
                // An issue while busy cannot happen (D is stalled); it is
                // simply ignored here.
                md_cnt_d = md_cnt_q - MD_CNT_W'(1);
                if (md_cnt_q == MD_CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    done_d = (md_cnt_q == MD_CNT_W'(2));
                end
            end
            default: begin
                state_d  = MD_IDLE;
                md_cnt_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= MD_IDLE;
            md_cnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;

    // Issuing into a busy unit means the D-stage stall failed.
    md_start_while_busy: assert property (
        @(posedge clk) disable iff (!reset) !(md_start && (state_q == MD_BUSY))
    );

endmodule

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
//   Hazard controller for the 5-stage pipeline. Compares D-stage operand needs
//   (T_use) against E/M producers (T_new, A3, RegWrite); on a hazard it holds
//   PC and the D register and pushes a bubble into E. Also sequences the
//   multi-cycle mult/div unit and stalls HI/LO users in D while it is busy.
//
// Ports
//   clk    in      rising-edge clock
//   reset  in      synchronous active-low reset
//   bus    slave   stall_ctrl_if (D/E/M hazard inputs, stall/enable outputs,
//                  md_busy, md_done, stall_cnt)
//
// Optional feature (macro STALL_CNT_EN)
//   defined   : stall_cnt counts cycles with stall==1, wraps, reset clears
//   undefined : stall_cnt is tied to 0 and no counter exists
// -----------------------------------------------------------------------------
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    stall_ctrl_if.slave   bus
);

    logic haz_rs_e, haz_rs_m, haz_rt_e, haz_rt_m;
    logic grf_haz;
    logic md_haz;
    logic stall;
    logic md_busy;
    logic md_done;

    // W is never compared: its T_new is always 0, so it can never stall.
    assign haz_rs_e = grf_hazard(bus.D_rs, bus.D_Tuse_rs, bus.E_A3, bus.E_RegWrite, bus.E_Tnew);
    assign haz_rs_m = grf_hazard(bus.D_rs, bus.D_Tuse_rs, bus.M_A3, bus.M_RegWrite, bus.M_Tnew);
    assign haz_rt_e = grf_hazard(bus.D_rt, bus.D_Tuse_rt, bus.E_A3, bus.E_RegWrite, bus.E_Tnew);
    assign haz_rt_m = grf_hazard(bus.D_rt, bus.D_Tuse_rt, bus.M_A3, bus.M_RegWrite, bus.M_Tnew);

    assign grf_haz = haz_rs_e | haz_rs_m | haz_rt_e | haz_rt_m;

    // The issue cycle itself counts as busy for a following HI/LO user.
    assign md_haz = bus.D_md_use & (md_busy | bus.E_md_start);

    // No stall is reported while reset is held.
    assign stall = reset & (grf_haz | md_haz);

    md_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk      (clk),
        .reset    (reset),
        .md_start (bus.E_md_start),
        .md_div   (bus.E_md_div),
        .md_busy  (md_busy),
        .md_done  (md_done)
    );

    assign bus.stall   = stall;
    assign bus.PC_en   = ~stall;
    assign bus.D_en    = ~stall;
    assign bus.E_clr   = stall;
    assign bus.md_busy = md_busy;
    assign bus.md_done = md_done;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl
//   Self-checking bench for stall_ctrl: a table of GRF hazard vectors,
//   hand-written mult/div and reset sequences, a stall counter sequence and
//   randomized traffic, all compared against a behavioural model that tracks
//   "busy cycles remaining" and a stalled-cycle tally.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;
    import stall_ctrl_pkg::*;

    localparam int CNT_W = 32;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    stall_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model state
    int               md_rem = 0;
    logic [CNT_W-1:0] m_cnt  = '0;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tu_rs;
        logic [1:0] tu_rt;
        logic [4:0] ea3;
        logic       ewe;
        logic [1:0] etn;
        logic [4:0] ma3;
        logic       mwe;
        logic [1:0] mtn;
        logic       exp_stall;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.D_rs       = '0;
        bus.D_rt       = '0;
        bus.D_Tuse_rs  = TUSE_NONE;
        bus.D_Tuse_rt  = TUSE_NONE;
        bus.D_md_use   = 1'b0;
        bus.E_A3       = '0;
        bus.M_A3       = '0;
        bus.E_RegWrite = 1'b0;
        bus.M_RegWrite = 1'b0;
        bus.E_Tnew     = '0;
        bus.M_Tnew     = '0;
        bus.E_md_start = 1'b0;
        bus.E_md_div   = 1'b0;
    endtask

    // Stall as the rules state it, evaluated over every source/producer pair.
    function automatic bit model_stall();
        int src [2];
        int tu  [2];
        int a3  [2];
        bit we  [2];
        int tn  [2];
        bit h;
        if (reset !== 1'b1) return 1'b0;
        src = '{int'(bus.D_rs), int'(bus.D_rt)};
        tu  = '{int'(bus.D_Tuse_rs), int'(bus.D_Tuse_rt)};
        a3  = '{int'(bus.E_A3), int'(bus.M_A3)};
        we  = '{bus.E_RegWrite, bus.M_RegWrite};
        tn  = '{int'(bus.E_Tnew), int'(bus.M_Tnew)};
        h = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (src[i] != 0 && we[j] && a3[j] == src[i] && tu[i] < tn[j]) h = 1'b1;
        if (bus.D_md_use && (md_rem > 0 || bus.E_md_start)) h = 1'b1;
        return h;
    endfunction

    task automatic at_sample();
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        bit s;
        s = model_stall();
        chk({tag, ".stall"},     bus.stall,     s);
        chk({tag, ".PC_en"},     bus.PC_en,     !s);
        chk({tag, ".D_en"},      bus.D_en,      !s);
        chk({tag, ".E_clr"},     bus.E_clr,     s);
        chk({tag, ".md_busy"},   bus.md_busy,   md_rem > 0);
        chk({tag, ".md_done"},   bus.md_done,   md_rem == 1);
        chk({tag, ".stall_cnt"}, bus.stall_cnt, m_cnt);
    endtask

    // Move the model across one rising edge using the inputs held now.
    task automatic advance();
        bit s;
        s = model_stall();
        @(posedge clk);
        if (reset !== 1'b1) begin
            md_rem = 0;
            m_cnt  = '0;
        end else begin
            if (CNT_EN && s) m_cnt = m_cnt + 1'b1;
            if (md_rem > 0) md_rem--;
            else if (bus.E_md_start) md_rem = bus.E_md_div ? DIV_N : MULT_N;
        end
        #1;
    endtask

    initial begin
        int busy_cycles, stall_cycles, done_pulses, done_idx, last_busy_idx;

        tbl[0]  = '{"e_rs_tuse0",  5'd5,  5'd0, 2'd0, 2'd3, 5'd5, 1'b1, 2'd2, 5'd0,  1'b0, 2'd0, 1'b1};
        tbl[1]  = '{"e_rs_tuse2",  5'd5,  5'd0, 2'd2, 2'd3, 5'd5, 1'b1, 2'd2, 5'd0,  1'b0, 2'd0, 1'b0};
        tbl[2]  = '{"e_rs_tuse1",  5'd5,  5'd0, 2'd1, 2'd3, 5'd5, 1'b1, 2'd2, 5'd0,  1'b0, 2'd0, 1'b1};
        tbl[3]  = '{"m_rt_tuse0",  5'd0,  5'd8, 2'd3, 2'd0, 5'd0, 1'b0, 2'd0, 5'd8,  1'b1, 2'd1, 1'b1};
        tbl[4]  = '{"m_rt_zero",   5'd0,  5'd0, 2'd3, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0,  1'b1, 2'd1, 1'b0};
        tbl[5]  = '{"e_no_write",  5'd5,  5'd0, 2'd0, 2'd3, 5'd5, 1'b0, 2'd2, 5'd0,  1'b0, 2'd0, 1'b0};
        tbl[6]  = '{"e_a3_differ", 5'd6,  5'd0, 2'd0, 2'd3, 5'd5, 1'b1, 2'd2, 5'd0,  1'b0, 2'd0, 1'b0};
        tbl[7]  = '{"rt_not_used", 5'd0,  5'd7, 2'd3, 2'd3, 5'd7, 1'b1, 2'd3, 5'd0,  1'b0, 2'd0, 1'b0};
        tbl[8]  = '{"m_equal_t",   5'd9,  5'd0, 2'd1, 2'd3, 5'd0, 1'b0, 2'd0, 5'd9,  1'b1, 2'd1, 1'b0};
        tbl[9]  = '{"e_m_both_rt", 5'd0,  5'd4, 2'd3, 2'd0, 5'd4, 1'b1, 2'd1, 5'd4,  1'b1, 2'd1, 1'b1};
        tbl[10] = '{"zero_regs",   5'd0,  5'd0, 2'd0, 2'd0, 5'd0, 1'b1, 2'd3, 5'd0,  1'b1, 2'd3, 1'b0};
        tbl[11] = '{"m_rs_tnew2",  5'd12, 5'd0, 2'd1, 2'd3, 5'd0, 1'b0, 2'd0, 5'd12, 1'b1, 2'd2, 1'b1};

        // reset held with a live hazard on the inputs: stall must stay low
        clear_inputs();
        reset = 1'b0;
        bus.E_A3 = 5'd5; bus.E_RegWrite = 1'b1; bus.E_Tnew = 2'd2;
        bus.D_rs = 5'd5; bus.D_Tuse_rs = 2'd0;
        advance();
        advance();
        at_sample();
        chk("rst_stall",     bus.stall,     1'b0);
        chk("rst_pc_en",     bus.PC_en,     1'b1);
        chk("rst_e_clr",     bus.E_clr,     1'b0);
        chk("rst_md_busy",   bus.md_busy,   1'b0);
        chk("rst_md_done",   bus.md_done,   1'b0);
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
        advance();
        reset = 1'b1;
        clear_inputs();
        advance();

        // GRF hazard table
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            bus.D_rs       = tbl[i].rs;
            bus.D_rt       = tbl[i].rt;
            bus.D_Tuse_rs  = tbl[i].tu_rs;
            bus.D_Tuse_rt  = tbl[i].tu_rt;
            bus.E_A3       = tbl[i].ea3;
            bus.E_RegWrite = tbl[i].ewe;
            bus.E_Tnew     = tbl[i].etn;
            bus.M_A3       = tbl[i].ma3;
            bus.M_RegWrite = tbl[i].mwe;
            bus.M_Tnew     = tbl[i].mtn;
            at_sample();
            chk(tbl[i].name, bus.stall, tbl[i].exp_stall);
            chk({tbl[i].name, ".pc_en"}, bus.PC_en, !tbl[i].exp_stall);
            compare_model("tbl");
            advance();
        end

        // mult issue with a HI/LO user waiting in D the whole time
        clear_inputs();
        busy_cycles = 0; stall_cycles = 0; done_pulses = 0; done_idx = -1; last_busy_idx = -1;
        bus.D_md_use = 1'b1;
        bus.E_md_start = 1'b1;
        bus.E_md_div = 1'b0;
        for (int c = 0; c < 9; c++) begin
            at_sample();
            compare_model("mul");
            if (bus.stall === 1'b1) stall_cycles++;
            if (bus.md_busy === 1'b1) begin busy_cycles++; last_busy_idx = c; end
            if (bus.md_done === 1'b1) begin done_pulses++; done_idx = c; end
            advance();
            bus.E_md_start = 1'b0;
        end
        chk("mul_busy_cycles",  busy_cycles,  5);
        chk("mul_stall_cycles", stall_cycles, 6);
        chk("mul_done_pulses",  done_pulses,  1);
        chk("mul_done_on_last", done_idx,     5);
        chk("mul_last_busy",    last_busy_idx, 5);

        // div issue, reset dropped during the 4th busy cycle
        clear_inputs();
        done_pulses = 0;
        bus.E_md_start = 1'b1;
        bus.E_md_div = 1'b1;
        at_sample();
        compare_model("div_issue");
        advance();
        bus.E_md_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            at_sample();
            compare_model("div_busy");
            chk("div_busy_on", bus.md_busy, 1'b1);
            if (bus.md_done === 1'b1) done_pulses++;
            if (c == 4) reset = 1'b0;
            advance();
        end
        at_sample();
        chk("div_abort_busy", bus.md_busy, 1'b0);
        chk("div_abort_done", bus.md_done, 1'b0);
        if (bus.md_done === 1'b1) done_pulses++;
        chk("div_no_done_pulse", done_pulses, 0);
        compare_model("div_abort");
        reset = 1'b1;
        advance();

        // stall counter: 3 hazard cycles, 2 clean, then reset
        clear_inputs();
        reset = 1'b0;
        advance();
        reset = 1'b1;
        bus.E_A3 = 5'd3; bus.E_RegWrite = 1'b1; bus.E_Tnew = 2'd2;
        bus.D_rs = 5'd3; bus.D_Tuse_rs = 2'd0;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) clear_inputs();
            at_sample();
            compare_model("scnt");
            advance();
        end
        at_sample();
        chk("scnt_after_3", bus.stall_cnt, CNT_EN ? 32'd3 : 32'd0);
        reset = 1'b0;
        advance();
        at_sample();
        chk("scnt_reset", bus.stall_cnt, 32'd0);
        reset = 1'b1;
        advance();

        // randomized traffic; never issue into a busy unit
        for (int c = 0; c < 3000; c++) begin
            bus.D_rs       = 5'($urandom_range(0, 3));
            bus.D_rt       = 5'($urandom_range(0, 3));
            bus.D_Tuse_rs  = 2'($urandom_range(0, 3));
            bus.D_Tuse_rt  = 2'($urandom_range(0, 3));
            bus.E_A3       = 5'($urandom_range(0, 3));
            bus.M_A3       = 5'($urandom_range(0, 3));
            bus.E_RegWrite = 1'($urandom_range(0, 1));
            bus.M_RegWrite = 1'($urandom_range(0, 1));
            bus.E_Tnew     = 2'($urandom_range(0, 3));
            bus.M_Tnew     = 2'($urandom_range(0, 3));
            bus.D_md_use   = ($urandom_range(0, 3) == 0);
            bus.E_md_div   = 1'($urandom_range(0, 1));
            bus.E_md_start = (md_rem == 0) && ($urandom_range(0, 7) == 0);
            reset          = ($urandom_range(0, 99) != 0);
            at_sample();
            compare_model("rnd");
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
